dc1_xbit_wrq: RTL and testbench

//  Store-side write queue for the L1D pbit side-array (dc1_xbit). Buffers up to two committed-store pbit

---
 rtl/dc1_xbit_pkg.sv | 38 +++
 rtl/dc1_xbit_wrq_fifo.sv | 44 ++++
 rtl/dc1_xbit_wrq.sv | 114 +++++++++++
 tb/tb_dc1_xbit_wrq.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dc1_xbit_pkg.sv
// dc1_xbit_pkg: shared entry type, address geometry and row/bank conflict test for the pbit write queue.
package dc1_xbit_pkg;
   localparam int ADDR_WIDTH = 5;
   localparam int XB_ADDR_W = ADDR_WIDTH + 5;
   localparam int XB_ROW_LSB = 4;
   localparam int XB_ROW_W = XB_ADDR_W - XB_ROW_LSB;

   typedef struct packed {
      logic [XB_ADDR_W-1:0] addr_e;
      logic [XB_ADDR_W-1:0] addr_o;
      logic                 odd;
      logic [1:0]           pbit;
      logic                 d128;
   } dc1_xbit_wr_t;

   // banks[0]=even, banks[1]=odd; rows include the half bit
   typedef struct packed {
      logic [1:0]          banks;
      logic [XB_ROW_W-1:0] row_e;
      logic [XB_ROW_W-1:0] row_o;
   } dc1_xbit_touch_t;

   function automatic dc1_xbit_touch_t xb_touch(input logic [XB_ADDR_W-1:0] ae, ao,
                                                input logic odd, d128, en);
      dc1_xbit_touch_t t;
      logic [3:0] lo;
      lo = odd ? ao[3:0] : ae[3:0];
      t.banks = !en ? 2'b00 : (lo == 4'hf && d128) ? 2'b11 : odd ? 2'b10 : 2'b01;
      t.row_e = ae[XB_ADDR_W-1:XB_ROW_LSB];
      t.row_o = ao[XB_ADDR_W-1:XB_ROW_LSB];
      return t;
   endfunction

   function automatic logic xb_conflict(input dc1_xbit_touch_t a, b);
      return (a.banks[0] & b.banks[0] & (a.row_e == b.row_e)) |
             (a.banks[1] & b.banks[1] & (a.row_o == b.row_o));
   endfunction
endpackage

// File: rtl/dc1_xbit_wrq_fifo.sv
// dc1_xbit_wrq_fifo: 2-write/2-read circular buffer with occupancy count.
module dc1_xbit_wrq_fifo
   import dc1_xbit_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push0,
   input  logic                       push1,
   input  dc1_xbit_wr_t               din0,
   input  dc1_xbit_wr_t               din1,
   input  logic [1:0]                 pop,
   output dc1_xbit_wr_t               head0,
   output dc1_xbit_wr_t               head1,
   output logic [$clog2(DEPTH):0]     count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [PW-1:0] ONE = 1;

   dc1_xbit_wr_t mem [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;

   assign head0 = mem[rd_ptr];
   assign head1 = mem[rd_ptr + ONE];

   always_ff @(posedge clk) begin
      if (push0) mem[wr_ptr] <= din0;
      if (push1) mem[wr_ptr + ONE] <= din1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         wr_ptr <= wr_ptr + PW'(push0) + PW'(push1);
         rd_ptr <= rd_ptr + PW'(pop);
         count  <= count + CW'(push0) + CW'(push1) - CW'(pop);
      end
   end
endmodule

// File: rtl/dc1_xbit_wrq.sv
// dc1_xbit_wrq: store-side pbit write queue; drains up to two hazard-free entries per cycle
// onto the array write ports, with fill inserts taking absolute priority.
module dc1_xbit_wrq
   import dc1_xbit_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 st0_valid,
   input  logic [XB_ADDR_W-1:0] st0_addrE,
   input  logic [XB_ADDR_W-1:0] st0_addrO,
   input  logic                 st0_odd,
   input  logic [1:0]           st0_pbit,
   input  logic                 st0_d128,
   input  logic                 st1_valid,
   input  logic [XB_ADDR_W-1:0] st1_addrE,
   input  logic [XB_ADDR_W-1:0] st1_addrO,
   input  logic                 st1_odd,
   input  logic [1:0]           st1_pbit,
   input  logic                 st1_d128,
   output logic                 st_ready,
   input  logic [1:0]           ins_bank,
   input  logic [XB_ADDR_W-1:0] ins_addrE,
   input  logic [XB_ADDR_W-1:0] ins_addrO,
   input  logic [15:0]          ins_data,
   output logic                 write0_clkEn,
   output logic [XB_ADDR_W-1:0] write0_addrE,
   output logic [XB_ADDR_W-1:0] write0_addrO,
   output logic                 write0_odd,
   output logic [1:0]           write0_pbit,
   output logic                 write0_d128,
   output logic                 write1_clkEn,
   output logic [XB_ADDR_W-1:0] write1_addrE,
   output logic [XB_ADDR_W-1:0] write1_addrO,
   output logic                 write1_odd,
   output logic [1:0]           write1_pbit,
   output logic                 write1_d128,
   output logic [1:0]           write_ins,
   output logic [15:0]          write_data,
   output logic                 wrq_empty
);
   localparam int CW = $clog2(DEPTH) + 1;

   dc1_xbit_wr_t st0, st1, head0, head1, w0, w1, w0_nx, w1_nx;
   dc1_xbit_touch_t t0, t1, last0, last1, last_ins;
   logic [CW-1:0] count;
   logic [1:0] pop, ins_q;
   logic [15:0] data_q;
   logic push0, push1, en0, en1, ins, haz0, haz1, iss0, iss1;

   assign st0 = '{st0_addrE, st0_addrO, st0_odd, st0_pbit, st0_d128};
   assign st1 = '{st1_addrE, st1_addrO, st1_odd, st1_pbit, st1_d128};
   assign st_ready = count <= CW'(DEPTH - 2);
   assign push0 = st_ready & st0_valid;
   assign push1 = push0 & st1_valid;

   dc1_xbit_wrq_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk(clk), .rst(rst), .push0(push0), .push1(push1), .din0(st0), .din1(st1),
      .pop(pop), .head0(head0), .head1(head1), .count(count)
   );

   // The output registers double as the record of last cycle's writes for the RMW check
   assign last0 = xb_touch(w0.addr_e, w0.addr_o, w0.odd, w0.d128, en0);
   assign last1 = xb_touch(w1.addr_e, w1.addr_o, w1.odd, w1.d128, en1);
   assign last_ins = '{ins_q, w0.addr_e[XB_ADDR_W-1:XB_ROW_LSB], w0.addr_o[XB_ADDR_W-1:XB_ROW_LSB]};
   assign t0 = xb_touch(head0.addr_e, head0.addr_o, head0.odd, head0.d128, 1'b1);
   assign t1 = xb_touch(head1.addr_e, head1.addr_o, head1.odd, head1.d128, 1'b1);

   always_comb begin
      ins   = |ins_bank;
      haz0  = xb_conflict(t0, last0) | xb_conflict(t0, last1) | xb_conflict(t0, last_ins);
      haz1  = xb_conflict(t1, last0) | xb_conflict(t1, last1) | xb_conflict(t1, last_ins);
      iss0  = !ins && count != '0 && !haz0;
      iss1  = iss0 && count > CW'(1) && !xb_conflict(t0, t1) && !haz1;
      pop   = {iss1, iss0 & ~iss1};
      w0_nx = ins ? dc1_xbit_wr_t'({ins_addrE, ins_addrO, 4'b0}) : iss0 ? head0 : '0;
      w1_nx = iss1 ? head1 : '0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         en0    <= 1'b0;
         en1    <= 1'b0;
         w0     <= '0;
         w1     <= '0;
         ins_q  <= '0;
         data_q <= '0;
      end else begin
         en0    <= iss0;
         en1    <= iss1;
         w0     <= w0_nx;
         w1     <= w1_nx;
         ins_q  <= ins_bank;
         data_q <= ins ? ins_data : '0;
      end
   end

   assign write0_clkEn = en0;
   assign write0_addrE = w0.addr_e;
   assign write0_addrO = w0.addr_o;
   assign write0_odd   = w0.odd;
   assign write0_pbit  = w0.pbit;
   assign write0_d128  = w0.d128;
   assign write1_clkEn = en1;
   assign write1_addrE = w1.addr_e;
   assign write1_addrO = w1.addr_o;
   assign write1_odd   = w1.odd;
   assign write1_pbit  = w1.pbit;
   assign write1_d128  = w1.d128;
   assign write_ins    = ins_q;
   assign write_data   = data_q;
   assign wrq_empty    = (count == '0) & ~en0 & ~en1 & ~|ins_q;
endmodule

// File: tb/tb_dc1_xbit_wrq.sv
// tb_dc1_xbit_wrq: directed and random stimulus against a queue/key-set reference model.
module tb_dc1_xbit_wrq;
   localparam int DEPTH = 8;

   logic clk = 0, rst;
   logic st0_valid, st0_odd, st0_d128, st1_valid, st1_odd, st1_d128, st_ready;
   logic [9:0] st0_addrE, st0_addrO, st1_addrE, st1_addrO, ins_addrE, ins_addrO;
   logic [1:0] st0_pbit, st1_pbit, ins_bank, write_ins;
   logic [15:0] ins_data, write_data;
   logic write0_clkEn, write0_odd, write0_d128, write1_clkEn, write1_odd, write1_d128, wrq_empty;
   logic [9:0] write0_addrE, write0_addrO, write1_addrE, write1_addrO;
   logic [1:0] write0_pbit, write1_pbit;

   dc1_xbit_wrq #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .st0_valid(st0_valid), .st0_addrE(st0_addrE), .st0_addrO(st0_addrO), .st0_odd(st0_odd),
      .st0_pbit(st0_pbit), .st0_d128(st0_d128),
      .st1_valid(st1_valid), .st1_addrE(st1_addrE), .st1_addrO(st1_addrO), .st1_odd(st1_odd),
      .st1_pbit(st1_pbit), .st1_d128(st1_d128), .st_ready(st_ready),
      .ins_bank(ins_bank), .ins_addrE(ins_addrE), .ins_addrO(ins_addrO), .ins_data(ins_data),
      .write0_clkEn(write0_clkEn), .write0_addrE(write0_addrE), .write0_addrO(write0_addrO),
      .write0_odd(write0_odd), .write0_pbit(write0_pbit), .write0_d128(write0_d128),
      .write1_clkEn(write1_clkEn), .write1_addrE(write1_addrE), .write1_addrO(write1_addrO),
      .write1_odd(write1_odd), .write1_pbit(write1_pbit), .write1_d128(write1_d128),
      .write_ins(write_ins), .write_data(write_data), .wrq_empty(wrq_empty)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [9:0] ae, ao;
      logic odd;
      logic [1:0] pbit;
      logic d128;
   } ent_t;
   typedef int kq_t[$];

   int checks = 0, failures = 0;
   ent_t q[$];
   kq_t last_keys;
   bit e_en0, e_en1;
   ent_t e_w0, e_w1;
   logic [1:0] e_ins;
   logic [15:0] e_data;
   logic [9:0] e_iae, e_iao;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic ent_t mk(input int row, input bit odd, input int b, input bit d128, input logic [1:0] pb);
      ent_t e;
      e.ae = 10'(row * 16 + b);
      e.ao = 10'(row * 16 + b);
      e.odd = odd;
      e.pbit = pb;
      e.d128 = d128;
      return e;
   endfunction

   // each touched (bank,row) becomes a key bank*64+row; wide entries spill into the other bank
   function automatic kq_t keys_of(input ent_t e);
      kq_t k;
      logic [9:0] a;
      a = e.odd ? e.ao : e.ae;
      k.push_back(e.odd ? 64 + int'(e.ao[9:4]) : int'(e.ae[9:4]));
      if (a[3:0] == 4'hf && e.d128) k.push_back(e.odd ? int'(e.ae[9:4]) : 64 + int'(e.ao[9:4]));
      return k;
   endfunction

   function automatic bit overlap(input kq_t a, input kq_t b);
      foreach (a[i]) foreach (b[j]) if (a[i] == b[j]) return 1;
      return 0;
   endfunction

   task automatic model_step();
      kq_t nk, kk;
      int n = 0;
      bit rdy = (DEPTH - q.size()) >= 2;
      if (ins_bank == 0 && q.size() > 0 && !overlap(keys_of(q[0]), last_keys)) begin
         n = 1;
         if (q.size() > 1 && !overlap(keys_of(q[1]), keys_of(q[0])) && !overlap(keys_of(q[1]), last_keys)) n = 2;
      end
      e_en0 = n >= 1;
      e_en1 = n == 2;
      if (n >= 1) e_w0 = q[0];
      if (n == 2) e_w1 = q[1];
      e_ins = ins_bank;
      e_data = ins_data;
      e_iae = ins_addrE;
      e_iao = ins_addrO;
      for (int i = 0; i < n; i++) begin
         kk = keys_of(q[i]);
         foreach (kk[j]) nk.push_back(kk[j]);
      end
      if (ins_bank[0]) nk.push_back(int'(ins_addrE[9:4]));
      if (ins_bank[1]) nk.push_back(64 + int'(ins_addrO[9:4]));
      last_keys = nk;
      repeat (n) void'(q.pop_front());
      if (rdy && st0_valid) q.push_back('{st0_addrE, st0_addrO, st0_odd, st0_pbit, st0_d128});
      if (rdy && st0_valid && st1_valid) q.push_back('{st1_addrE, st1_addrO, st1_odd, st1_pbit, st1_d128});
   endtask

   task automatic check_outs();
      chk("en0", write0_clkEn, e_en0);
      chk("en1", write1_clkEn, e_en1);
      if (e_en0) begin
         chk("w0_ae", write0_addrE, e_w0.ae);
         chk("w0_ao", write0_addrO, e_w0.ao);
         chk("w0_fields", {write0_odd, write0_pbit, write0_d128}, {e_w0.odd, e_w0.pbit, e_w0.d128});
      end
      if (e_en1) begin
         chk("w1_ae", write1_addrE, e_w1.ae);
         chk("w1_ao", write1_addrO, e_w1.ao);
         chk("w1_fields", {write1_odd, write1_pbit, write1_d128}, {e_w1.odd, e_w1.pbit, e_w1.d128});
      end
      chk("ins", write_ins, e_ins);
      if (e_ins != 0) begin
         chk("ins_data", write_data, e_data);
         chk("ins_ae", write0_addrE, e_iae);
         chk("ins_ao", write0_addrO, e_iao);
      end
      chk("ready", st_ready, (DEPTH - q.size()) >= 2);
      chk("empty", wrq_empty, q.size() == 0 && !e_en0 && !e_en1 && e_ins == 0);
   endtask

   task automatic idle_inputs();
      st0_valid = 0; st1_valid = 0; ins_bank = 0;
      {st0_addrE, st0_addrO, st0_odd, st0_pbit, st0_d128} = '0;
      {st1_addrE, st1_addrO, st1_odd, st1_pbit, st1_d128} = '0;
      ins_addrE = 0; ins_addrO = 0; ins_data = 0;
   endtask

   task automatic drive(input ent_t a, input bit va, input ent_t b, input bit vb);
      st0_valid = va; st0_addrE = a.ae; st0_addrO = a.ao; st0_odd = a.odd; st0_pbit = a.pbit; st0_d128 = a.d128;
      st1_valid = vb; st1_addrE = b.ae; st1_addrO = b.ao; st1_odd = b.odd; st1_pbit = b.pbit; st1_d128 = b.d128;
   endtask

   task automatic cyc();
      model_step();
      @(posedge clk);
      #1;
      check_outs();
      idle_inputs();
   endtask

   task automatic do_reset();
      #3 rst = 0;
      #1;
      q.delete(); last_keys.delete();
      e_en0 = 0; e_en1 = 0; e_ins = 0;
      chk("rst_en0", write0_clkEn, 0);
      chk("rst_en1", write1_clkEn, 0);
      chk("rst_ins", write_ins, 0);
      chk("rst_ready", st_ready, 1);
      chk("rst_empty", wrq_empty, 1);
      idle_inputs();
      @(posedge clk);
      #1 rst = 1;
   endtask

   initial begin
      ent_t a, b;
      rst = 0;
      idle_inputs();
      repeat (2) @(posedge clk);
      #1;
      chk("init_en0", write0_clkEn, 0);
      chk("init_ready", st_ready, 1);
      chk("init_empty", wrq_empty, 1);
      rst = 1;
      // reset in the middle of traffic
      drive(mk(1, 0, 0, 0, 1), 1, mk(1, 0, 1, 0, 2), 1); cyc();
      drive(mk(2, 1, 0, 0, 3), 1, mk(4, 0, 5, 0, 1), 1); cyc();
      do_reset();
      // two different rows/banks issue together two cycles after enqueue
      drive(mk(3, 0, 1, 0, 2), 1, mk(5, 1, 6, 0, 1), 1); cyc();
      cyc();
      chk("t2_en", {write0_clkEn, write1_clkEn}, 2'b11);
      chk("t2_row0", write0_addrE[8:4], 3);
      chk("t2_row1", write1_addrO[8:4], 5);
      repeat (3) cyc();
      // same row, same bank: serialised plus one RMW hold cycle
      drive(mk(7, 0, 2, 0, 1), 1, mk(7, 0, 9, 0, 2), 1); cyc();
      cyc();
      chk("t3_first", {write0_clkEn, write1_clkEn, write0_addrE[3:0]}, {2'b10, 4'd2});
      cyc();
      chk("t3_hold", write0_clkEn, 0);
      cyc();
      chk("t3_second", {write0_clkEn, write0_addrE[3:0]}, {1'b1, 4'd9});
      repeat (3) cyc();
      // insert with four entries queued
      drive(mk(10, 0, 0, 0, 1), 1, mk(11, 1, 0, 0, 2), 1); ins_bank = 2'b10; ins_addrO = 10'(20 * 16); cyc();
      drive(mk(12, 0, 0, 0, 3), 1, mk(13, 1, 0, 0, 1), 1); ins_bank = 2'b10; ins_addrO = 10'(20 * 16); cyc();
      ins_bank = 2'b01; ins_addrE = 10'(21 * 16); ins_data = 16'ha5c3; cyc();
      chk("t4_ins", {write_ins, write_data, write0_clkEn, write1_clkEn}, {2'b01, 16'ha5c3, 2'b00});
      cyc();
      chk("t4_resume", {write0_clkEn, write0_addrE[8:4]}, {1'b1, 5'd10});
      repeat (4) cyc();
      // fill the queue under continuous inserts
      for (int i = 0; i < 5; i++) begin
         drive(mk(2 * i, 0, 3, 0, 1), 1, mk(2 * i + 1, 1, 4, 0, 2), 1);
         ins_bank = 2'b01; ins_addrE = 10'(30 * 16); ins_data = 16'(i);
         cyc();
         if (i == 2) chk("t5_ready6", st_ready, 1);
         if (i >= 3) chk("t5_full", st_ready, 0);
      end
      repeat (8) cyc();
      // wide entry spans both banks of row 2
      drive(mk(2, 0, 15, 1, 3), 1, mk(2, 1, 3, 0, 1), 1); cyc();
      cyc();
      chk("t6_alone", {write0_clkEn, write1_clkEn, write0_addrE[3:0]}, {2'b10, 4'hf});
      cyc();
      chk("t6_hold", write0_clkEn, 0);
      cyc();
      chk("t6_odd", {write0_clkEn, write0_odd, write0_addrO[8:4]}, {2'b11, 5'd2});
      repeat (3) cyc();
      // random traffic with a narrow row range to provoke hazards
      for (int i = 0; i < 400; i++) begin
         a = mk($urandom_range(0, 3), 1'($urandom), ($urandom_range(0, 2) == 0) ? 15 : $urandom_range(0, 15),
                1'($urandom), 2'($urandom));
         b = mk($urandom_range(0, 3), 1'($urandom), ($urandom_range(0, 2) == 0) ? 15 : $urandom_range(0, 15),
                1'($urandom), 2'($urandom));
         drive(a, $urandom_range(0, 9) < 6, b, 0);
         st1_valid = st0_valid && $urandom_range(0, 1) == 1;
         if ($urandom_range(0, 3) == 0) begin
            ins_bank = 2'($urandom_range(1, 3));
            ins_addrE = 10'($urandom_range(0, 3) * 16);
            ins_addrO = 10'($urandom_range(0, 3) * 16);
            ins_data = 16'($urandom);
         end
         cyc();
         if (i == 200) do_reset();
      end
      for (int i = 0; i < 60 && (q.size() > 0 || e_en0 || e_en1 || e_ins != 0); i++) cyc();
      chk("drained", wrq_empty, 1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
